// File: rtl/pll_reconfig_pkg.sv
// Shared definitions for the PLL reconfiguration sequencer: MD-port opcodes,
// PLL divider register addresses and the sequencer state encoding.
package pll_reconfig_pkg;

  // MD port opcodes
  localparam logic [1:0] MD_NOP   = 2'b00;
  localparam logic [1:0] MD_WRITE = 2'b01;
  localparam logic [1:0] MD_READ  = 2'b10;
  localparam logic [1:0] MD_ADDR  = 2'b11;

  // PLL divider register addresses on the MD port
  localparam logic [7:0] REG_ODIV0 = 8'h08;
  localparam logic [7:0] REG_ODIV1 = 8'h09;
  localparam logic [7:0] REG_ODIV2 = 8'h0A;
  localparam logic [7:0] REG_MDIV  = 8'h0B;

  // Sequencer states
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RST_ASSERT,
    ST_ADDR,
    ST_WRITE,
    ST_GAP,
    ST_READ,
    ST_RDWAIT,
    ST_VERIFY,
    ST_RST_RELEASE,
    ST_WAIT_LOCK,
    ST_RETRY,
    ST_DONE
  } state_t;

endpackage

// File: rtl/pll_reconfig_ctrl_rom.sv
// Divider profile table: (profile, register index) -> (MD address, data byte).
// Registers are written in the order ODIV0, ODIV1, ODIV2, MDIV.
// Profile 0 is the power-on divider set used by boot firmware.
module pll_profile_rom
  import pll_reconfig_pkg::*;
#(
  parameter int NUM_PROFILES     = 4,
  parameter int REGS_PER_PROFILE = 4,
  localparam int PW = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1,
  localparam int IW = (REGS_PER_PROFILE > 1) ? $clog2(REGS_PER_PROFILE) : 1
) (
  input  logic [PW-1:0] profile,
  input  logic [IW-1:0] idx,
  output logic [7:0]    addr,
  output logic [7:0]    data
);

  // Select one of four bytes by register index
  function automatic logic [7:0] pick(input int i, input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c, input logic [7:0] d);
    case (i)
      0:       return a;
      1:       return b;
      2:       return c;
      default: return d;
    endcase
  endfunction

  // Combinational table lookup; unknown profiles fall back to the power-on set
  always_comb begin
    addr = pick(int'(idx), REG_ODIV0, REG_ODIV1, REG_ODIV2, REG_MDIV);
    case (int'(profile))
      1:       data = pick(int'(idx), 8'd40, 8'd20, 8'd8,  8'd30);
      2:       data = pick(int'(idx), 8'd60, 8'd30, 8'd12, 8'd24);
      3:       data = pick(int'(idx), 8'd36, 8'd18, 8'd6,  8'd33);
      default: data = pick(int'(idx), 8'd50, 8'd25, 8'd10, 8'd27);
    endcase
  end

endmodule

// File: rtl/pll_reconfig_ctrl.sv
// PLL reconfiguration sequencer. On request it holds the PLL in reset, writes
// a divider profile through the MD port verifying each byte by read-back,
// releases reset and waits for a stable lock, retrying a bounded number of
// times before flagging a sticky error.
module pll_reconfig_ctrl
  import pll_reconfig_pkg::*;
#(
  parameter int NUM_PROFILES     = 4,
  parameter int REGS_PER_PROFILE = 4,
  parameter int RESET_HOLD       = 16,
  parameter int LOCK_TIMEOUT     = 65535,
  parameter int MAX_RETRY        = 3,
  localparam int PW = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1,
  localparam int IW = (REGS_PER_PROFILE > 1) ? $clog2(REGS_PER_PROFILE) : 1,
  localparam int HW = $clog2(RESET_HOLD + 1),
  localparam int TW = $clog2(LOCK_TIMEOUT + 1),
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  input  logic [PW-1:0] req_profile,
  output logic          req_ready,
  output logic          done,
  output logic          error,
  output logic          locked,
  output logic          pll_reset,
  input  logic          pll_lock,
  output logic          mdclk,
  output logic [1:0]    mdopc,
  output logic          mdainc,
  output logic [7:0]    mdwdi,
  input  logic [7:0]    mdrdo
);

  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_HOLD - 1);
  localparam logic [HW-1:0] RDWAIT_LAST = HW'(1);
  localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT);
  localparam logic [TW-1:0] TO_MAX    = '1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [IW-1:0] IDX_LAST  = IW'(REGS_PER_PROFILE - 1);

  state_t        state_reg;
  logic [PW-1:0] profile_reg;
  logic [IW-1:0] idx_reg;
  logic [HW-1:0] hold_cnt_reg;
  logic [TW-1:0] to_cnt_reg;
  logic [RW-1:0] retry_cnt_reg;
  logic [1:0]    lock_run_reg;
  logic [7:0]    exp_data_reg;
  logic [7:0]    rd_data_reg;
  logic [1:0]    lock_sync_reg;
  logic          lock_s;

  logic [IW-1:0] rom_idx;
  logic [7:0]    rom_addr;
  logic [7:0]    rom_data;

  assign mdclk     = clk;
  assign mdainc    = 1'b0;
  assign lock_s    = lock_sync_reg[1];
  assign req_ready = (state_reg == ST_IDLE);
  assign locked    = lock_s && (state_reg == ST_IDLE) && !error;

  // In VERIFY the table is pre-indexed with the next register so the ADDR
  // cycle can be issued straight away; the compared byte was captured earlier.
  assign rom_idx = (state_reg == ST_VERIFY) ? idx_reg + IW'(1) : idx_reg;

  pll_profile_rom #(
    .NUM_PROFILES     (NUM_PROFILES),
    .REGS_PER_PROFILE (REGS_PER_PROFILE)
  ) u_rom (
    .profile (profile_reg),
    .idx     (rom_idx),
    .addr    (rom_addr),
    .data    (rom_data)
  );

  // Two-flop synchronizer for the asynchronous PLL lock
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_sync_reg <= 2'b00;
    end else begin
      lock_sync_reg <= {lock_sync_reg[0], pll_lock};
    end
  end

  // Sequencer FSM; MD outputs are registered and set on entry to each state
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      done          <= 1'b0;
      error         <= 1'b0;
      pll_reset     <= 1'b1;
      mdopc         <= MD_NOP;
      mdwdi         <= 8'h00;
      profile_reg   <= '0;
      idx_reg       <= '0;
      hold_cnt_reg  <= '0;
      to_cnt_reg    <= '0;
      retry_cnt_reg <= '0;
      lock_run_reg  <= 2'd0;
      exp_data_reg  <= 8'h00;
      rd_data_reg   <= 8'h00;
    end else begin
      done  <= 1'b0;
      mdopc <= MD_NOP;
      mdwdi <= 8'h00;
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            profile_reg   <= req_profile;
            error         <= 1'b0;
            retry_cnt_reg <= '0;
            idx_reg       <= '0;
            hold_cnt_reg  <= '0;
            pll_reset     <= 1'b1;
            state_reg     <= ST_RST_ASSERT;
          end
        end

        ST_RST_ASSERT: begin
          if (hold_cnt_reg == HOLD_LAST) begin
            hold_cnt_reg <= '0;
            mdopc        <= MD_ADDR;
            mdwdi        <= rom_addr;
            state_reg    <= ST_ADDR;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + HW'(1);
          end
        end

        ST_ADDR: begin
          mdopc        <= MD_WRITE;
          mdwdi        <= rom_data;
          exp_data_reg <= rom_data;
          state_reg    <= ST_WRITE;
        end

        ST_WRITE: state_reg <= ST_GAP;

        ST_GAP: begin
          mdopc     <= MD_READ;
          state_reg <= ST_READ;
        end

        ST_READ: begin
          hold_cnt_reg <= '0;
          state_reg    <= ST_RDWAIT;
        end

        // Read data is valid on the second wait cycle; capture it then
        ST_RDWAIT: begin
          if (hold_cnt_reg == RDWAIT_LAST) begin
            rd_data_reg  <= mdrdo;
            hold_cnt_reg <= '0;
            state_reg    <= ST_VERIFY;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + HW'(1);
          end
        end

        ST_VERIFY: begin
          if (rd_data_reg != exp_data_reg) begin
            state_reg <= ST_RETRY;
          end else if (idx_reg == IDX_LAST) begin
            hold_cnt_reg <= '0;
            state_reg    <= ST_RST_RELEASE;
          end else begin
            idx_reg   <= idx_reg + IW'(1);
            mdopc     <= MD_ADDR;
            mdwdi     <= rom_addr;
            state_reg <= ST_ADDR;
          end
        end

        ST_RST_RELEASE: begin
          if (hold_cnt_reg == HOLD_LAST) begin
            hold_cnt_reg <= '0;
            pll_reset    <= 1'b0;
            to_cnt_reg   <= '0;
            lock_run_reg <= 2'd0;
            state_reg    <= ST_WAIT_LOCK;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + HW'(1);
          end
        end

        // Need four consecutive synchronized lock samples; glitches restart the run
        ST_WAIT_LOCK: begin
          if (lock_s && lock_run_reg == 2'd3) begin
            done      <= 1'b1;
            state_reg <= ST_DONE;
          end else if (to_cnt_reg == TO_LAST) begin
            state_reg <= ST_RETRY;
          end else begin
            if (to_cnt_reg != TO_MAX) begin
              to_cnt_reg <= to_cnt_reg + TW'(1);
            end
            lock_run_reg <= lock_s ? lock_run_reg + 2'd1 : 2'd0;
          end
        end

        // Either start a fresh attempt or give up, leaving the PLL in reset
        ST_RETRY: begin
          pll_reset <= 1'b1;
          if (retry_cnt_reg < RETRY_MAX) begin
            retry_cnt_reg <= retry_cnt_reg + RW'(1);
            idx_reg       <= '0;
            hold_cnt_reg  <= '0;
            state_reg     <= ST_RST_ASSERT;
          end else begin
            error     <= 1'b1;
            state_reg <= ST_IDLE;
          end
        end

        ST_DONE: state_reg <= ST_IDLE;

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reconfig_ctrl.sv
// Self-checking bench for pll_reconfig_ctrl with an MD-port register model
// and a PLL lock model driven by randomized profiles and lock delays.
module tb_pll_reconfig_ctrl;
  import pll_reconfig_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_profile = 2'd0;
  logic       req_ready, done, error, locked, pll_reset, pll_lock;
  logic       mdclk, mdainc;
  logic [1:0] mdopc;
  logic [7:0] mdwdi, mdrdo;

  pll_reconfig_ctrl #(.LOCK_TIMEOUT(200)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_profile (req_profile),
    .req_ready   (req_ready),
    .done        (done),
    .error       (error),
    .locked      (locked),
    .pll_reset   (pll_reset),
    .pll_lock    (pll_lock),
    .mdclk       (mdclk),
    .mdopc       (mdopc),
    .mdainc      (mdainc),
    .mdwdi       (mdwdi),
    .mdrdo       (mdrdo)
  );

  always #5 clk = ~clk;

  // Reference profile table and register order
  logic [7:0] prof_tab [4][4] = '{'{8'd50, 8'd25, 8'd10, 8'd27},
                                  '{8'd40, 8'd20, 8'd8,  8'd30},
                                  '{8'd60, 8'd30, 8'd12, 8'd24},
                                  '{8'd36, 8'd18, 8'd6,  8'd33}};
  logic [7:0] addr_tab [4] = '{REG_ODIV0, REG_ODIV1, REG_ODIV2, REG_MDIV};

  int total = 0;
  int bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // MD port model: address latch, register file, 2-cycle read latency
  logic [7:0] md_regs [256];
  logic [7:0] md_addr = 8'h00;
  logic [7:0] rd_pipe = 8'h00;
  logic       rd_pipe_v = 1'b0;
  logic [7:0] mdrdo_q = 8'h00;
  logic [7:0] corrupt_addr = 8'h00;
  int         corrupt_req = 0;
  int         corrupt_ack = 0;
  logic [7:0] log_addr [$];
  logic [7:0] log_data [$];

  assign mdrdo = mdrdo_q;

  always @(posedge clk) begin
    rd_pipe_v <= 1'b0;
    if (rd_pipe_v) mdrdo_q <= rd_pipe;
    case (mdopc)
      MD_ADDR: begin
        md_addr <= mdwdi;
        log_addr.push_back(mdwdi);
      end
      MD_WRITE: begin
        md_regs[md_addr] <= mdwdi;
        log_data.push_back(mdwdi);
      end
      MD_READ: begin
        rd_pipe_v <= 1'b1;
        if (corrupt_req != corrupt_ack && md_addr == corrupt_addr) begin
          rd_pipe     <= md_regs[md_addr] ^ 8'hFF;
          corrupt_ack <= corrupt_req;
        end else begin
          rd_pipe <= md_regs[md_addr];
        end
      end
      default: ;
    endcase
  end

  // PLL lock model: lock rises lock_delay edges after reset release
  int   lock_delay = 100;
  logic lock_never = 1'b0;
  logic glitch_en = 1'b0;
  logic lock_kill = 1'b0;
  int   since_rel = 0;
  logic lock_q = 1'b0;

  always @(posedge clk) begin
    if (pll_reset) begin
      since_rel <= 0;
      lock_q    <= 1'b0;
    end else begin
      since_rel <= since_rel + 1;
      lock_q    <= (!lock_never && since_rel + 1 >= lock_delay) ||
                   (glitch_en && (since_rel + 1 == 20 || since_rel + 1 == 21));
    end
  end
  assign pll_lock = lock_q && !lock_kill;

  // Event monitor: edge numbers of handshake, reset release and done
  int   cyc = 0, accept_cyc = 0, fall_cyc = 0, fall_cnt = 0, done_cyc = 0, done_cnt = 0;
  logic prev_rst = 1'b1;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (req_valid && req_ready && !reset) accept_cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    prev_rst <= pll_reset;
    if (prev_rst && !pll_reset) begin
      fall_cyc <= cyc;
      fall_cnt <= fall_cnt + 1;
    end
    if (done) begin
      done_cyc <= cyc;
      done_cnt <= done_cnt + 1;
    end
  end

  task automatic do_request(input int p);
    int n = 0;
    while (!req_ready && n < 5000) begin
      tick();
      n++;
    end
    check_eq("ready_before_req", req_ready, 1);
    req_valid   = 1'b1;
    req_profile = p[1:0];
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!req_ready && n < 4000) begin
      tick();
      n++;
    end
    check_eq(tag, req_ready, 1);
  endtask

  // Compare logged MD writes from 'base' against the expected index list
  task automatic check_writes(input int p, input int base, input int exp_idx[$]);
    check_eq("n_addr", log_addr.size() - base, exp_idx.size());
    check_eq("n_data", log_data.size() - base, exp_idx.size());
    if (log_addr.size() - base == exp_idx.size() && log_data.size() - base == exp_idx.size()) begin
      foreach (exp_idx[k]) begin
        check_eq("wr_addr", log_addr[base + k], addr_tab[exp_idx[k]]);
        check_eq("wr_data", log_data[base + k], prof_tab[p][exp_idx[k]]);
      end
    end
  endtask

  // One full program sequence: ci >= 0 corrupts the first readback of register ci
  task automatic run_seq(input int p, input int d, input int ci, input bit poke, input bit glitch);
    int base, done0, fall0, exp_rst;
    int exp_idx[$];
    base  = log_addr.size();
    done0 = done_cnt;
    fall0 = fall_cnt;
    lock_delay = d;
    glitch_en  = glitch;
    if (ci >= 0) begin
      corrupt_addr = addr_tab[ci];
      corrupt_req++;
      for (int i = 0; i <= ci; i++) exp_idx.push_back(i);
    end
    for (int i = 0; i < 4; i++) exp_idx.push_back(i);
    exp_rst = 60 + ((ci >= 0) ? 16 + 7 * (ci + 1) + 1 : 0);

    do_request(p);
    check_eq("err_clr", error, 0);
    if (poke) begin
      repeat (30) tick();
      req_valid   = 1'b1;
      req_profile = 2'd3;
      tick();
      req_valid = 1'b0;
    end
    wait_idle("seq_idle");
    tick();
    glitch_en = 1'b0;

    check_writes(p, base, exp_idx);
    check_eq("done_cnt", done_cnt - done0, 1);
    check_eq("fall_cnt", fall_cnt - fall0, 1);
    check_eq("rst_len", fall_cyc - accept_cyc, exp_rst);
    check_eq("lock_lat", done_cyc - fall_cyc, d + 6);
    check_eq("error", error, 0);
    check_eq("locked", locked, 1);
    check_eq("pll_rst", pll_reset, 0);
    $display("seq profile=%0d lock_delay=%0d corrupt=%0d poke=%0d glitch=%0d writes=%0d rst_cycles=%0d lock_to_done=%0d",
             p, d, ci, poke, glitch, log_addr.size() - base, fall_cyc - accept_cyc, done_cyc - fall_cyc);
  endtask

  initial begin
    int n, base, done0, fall0;
    int exp_idx[$];

    // Reset state
    reset = 1'b1;
    repeat (3) tick();
    check_eq("rst_ready", req_ready, 1);
    check_eq("rst_done", done, 0);
    check_eq("rst_error", error, 0);
    check_eq("rst_locked", locked, 0);
    check_eq("rst_pll_reset", pll_reset, 1);
    check_eq("rst_mdopc", mdopc, 0);
    check_eq("rst_mdwdi", mdwdi, 0);
    check_eq("rst_mdainc", mdainc, 0);
    check_eq("mdclk_hi", mdclk, 1);
    @(negedge clk);
    #1;
    check_eq("mdclk_lo", mdclk, 0);
    reset = 1'b0;

    // No automatic programming after reset
    repeat (20) tick();
    check_eq("noauto_rst", pll_reset, 1);
    check_eq("noauto_md", log_addr.size(), 0);
    $display("reset released, idle with pll_reset=%0d", pll_reset);

    run_seq(0, 100, -1, 1'b0, 1'b0);   // boot profile
    run_seq(1, 100, -1, 1'b0, 1'b0);   // clean program
    run_seq(1, 100, 2, 1'b0, 1'b0);    // readback mismatch on register 2
    run_seq(1, 100, -1, 1'b1, 1'b0);   // request while busy
    run_seq(1, 100, -1, 1'b0, 1'b1);   // lock glitch before stable lock
    for (int t = 0; t < 4; t++) begin
      run_seq(int'($urandom_range(0, 3)), int'($urandom_range(20, 150)),
              ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 3)) : -1, 1'b0, 1'b0);
    end

    // Lock loss in IDLE: locked drops two cycles later, no reprogram
    lock_kill = 1'b1;
    tick();
    check_eq("loss_1cyc", locked, 1);
    tick();
    check_eq("loss_2cyc", locked, 0);
    repeat (10) tick();
    check_eq("loss_ready", req_ready, 1);
    check_eq("loss_pll_rst", pll_reset, 0);
    lock_kill = 1'b0;
    $display("lock loss observed, locked=%0d", locked);
    repeat (4) tick();

    // Reset during READ of register 1
    do_request(3);
    n = 0;
    while (!(mdopc == MD_READ && md_addr == addr_tab[1]) && n < 300) begin
      tick();
      n++;
    end
    check_eq("mr_found", (n < 300) ? 1 : 0, 1);
    reset = 1'b1;
    tick();
    check_eq("mr_mdopc", mdopc, 0);
    check_eq("mr_mdwdi", mdwdi, 0);
    check_eq("mr_pll_rst", pll_reset, 1);
    check_eq("mr_ready", req_ready, 1);
    check_eq("mr_locked", locked, 0);
    check_eq("mr_done", done, 0);
    reset = 1'b0;
    $display("mid-sequence reset applied at READ of register 1");
    repeat (3) tick();

    // Lock timeout: four attempts then sticky error
    lock_never = 1'b1;
    base  = log_addr.size();
    done0 = done_cnt;
    fall0 = fall_cnt;
    for (int a = 0; a < 4; a++) for (int i = 0; i < 4; i++) exp_idx.push_back(i);
    do_request(2);
    wait_idle("to_idle");
    tick();
    check_writes(2, base, exp_idx);
    check_eq("to_attempts", fall_cnt - fall0, 4);
    check_eq("to_no_done", done_cnt - done0, 0);
    check_eq("to_error", error, 1);
    check_eq("to_pll_rst", pll_reset, 1);
    check_eq("to_ready", req_ready, 1);
    check_eq("to_locked", locked, 0);
    $display("timeout sequence: attempts=%0d error=%0d", fall_cnt - fall0, error);
    lock_never = 1'b0;

    // Next request clears the error and completes
    run_seq(0, 50, -1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
